// File: rtl/usb_slave_fifo_writer_pkg.sv
// Shared types and constants for the FX2 slave-FIFO writer.
package usb_pkg;

  // Writer FSM states, one per kind of halfword plus the packet-end pulse.
  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LO,
    HI,
    PKTEND
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h55AA;

  // One buffered result word: {sop, eop, data[31:0]}.
  localparam int ENTRY_W = 34;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } entry_t;

  // First state for a freshly popped word: a frame start gets a header.
  function automatic state_t first_state(input logic sop, input logic header_en);
    return (sop && header_en) ? HDR0 : LO;
  endfunction

endpackage

// File: rtl/usb_slave_fifo_writer_sync_fifo.sv
// Single-clock FIFO with a registered, first-word-fall-through read port.
// rd_data always holds the oldest entry while the FIFO is non-empty; after a
// pop the following entry appears in rd_data on the next cycle.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_ptr_n;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (level == LW'(DEPTH));

  // Storage array: written on push only.
  // NOTE: the array has no reset; stale contents are never observed because
  // empty gates every read, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update and head-of-queue register, with bypass when the entry
  // being written becomes the new head in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr_n;
      rd_data <= (push && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/usb_slave_fifo_writer.sv
// Buffers 32-bit result words and writes them as 16-bit halfwords (low half
// first) to a Cypress FX2 slave FIFO, with an optional sync/frame-counter
// header per frame and an optional pktend pulse at end of frame.
module usb_slave_fifo_writer
  import usb_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter bit          HEADER_EN = 1'b1,
  parameter bit          PKTEND_EN = 1'b1
) (
  input  logic                   ifclk,
  input  logic                   reset,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  output logic                   in_ready,
  input  logic                   flaga,
  output logic [15:0]            fd,
  output logic                   slwr,
  output logic                   pktend,
  output logic [15:0]            frame_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  entry_t      wr_entry;
  entry_t      rd_entry;
  entry_t      hold;
  entry_t      hold_n;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        full_next;

  state_t      state;
  state_t      state_n;
  logic        strobe;     // 0: setup cycle next, 1: waiting for flaga
  logic        strobe_n;
  logic [15:0] fd_n;
  logic        slwr_n;
  logic        pktend_n;
  logic        cnt_inc;
  logic [15:0] halfword;

  assign push     = in_valid & in_ready;
  assign wr_entry = '{sop: in_sop, eop: in_eop, data: in_data};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ifclk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // in_ready is registered, so a push can never hit a full FIFO; the only
  // ways to be full after this edge are staying full or filling the last slot.
  assign full_next = (full && !pop) ||
                     ((fifo_level == LW'(DEPTH - 1)) && push && !pop);

  // Input-side flow control register.
  always_ff @(posedge ifclk) begin
    if (reset) in_ready <= 1'b0;
    else       in_ready <= !full_next;
  end

  // Halfword presented on fd for the current write state.
  always_comb begin
    case (state)
      HDR0:    halfword = SYNC_WORD;
      HDR1:    halfword = frame_cnt;
      LO:      halfword = hold.data[15:0];
      HI:      halfword = hold.data[31:16];
      default: halfword = fd;
    endcase
  end

  // Next-state and output logic. Each halfword state spends one setup cycle
  // loading fd, then strobes slwr low once flaga is seen high.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_n  = state;
    strobe_n = strobe;
    hold_n   = hold;
    fd_n     = fd;
    slwr_n   = 1'b1;
    pktend_n = 1'b1;
    cnt_inc  = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_n  = rd_entry;
          state_n = first_state(rd_entry.sop, HEADER_EN);
        end
      end
      PKTEND: begin
        pktend_n = 1'b0;
        state_n  = IDLE;
      end
      HDR0, HDR1, LO, HI: begin
        if (!strobe) begin
          fd_n     = halfword;
          strobe_n = 1'b1;
        end else if (flaga) begin
          slwr_n   = 1'b0;
          strobe_n = 1'b0;
          case (state)
            HDR0: state_n = HDR1;
            HDR1: begin
              cnt_inc = 1'b1;
              state_n = LO;
            end
            LO:   state_n = HI;
            default: begin
              if (hold.eop && PKTEND_EN) begin
                state_n = PKTEND;
              end else if (!empty) begin
                pop     = 1'b1;
                hold_n  = rd_entry;
                state_n = first_state(rd_entry.sop, HEADER_EN);
              end else begin
                state_n = IDLE;
              end
            end
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM and FX2 output registers; reset forces slwr/pktend inactive at once.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state  <= IDLE;
      strobe <= 1'b0;
      hold   <= '0;
      fd     <= '0;
      slwr   <= 1'b1;
      pktend <= 1'b1;
    end else begin
      state  <= state_n;
      strobe <= strobe_n;
      hold   <= hold_n;
      fd     <= fd_n;
      slwr   <= slwr_n;
      pktend <= pktend_n;
    end
  end

  // Frame counter advances on the strobe of the counter halfword and wraps.
  always_ff @(posedge ifclk) begin
    if (reset)        frame_cnt <= '0;
    else if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_usb_slave_fifo_writer.sv
// Directed bench for usb_slave_fifo_writer: records every slwr strobe and
// pktend pulse seen on the FX2 side and compares them to hand-built sequences.
module tb_usb_slave_fifo_writer;

  localparam int          DEPTH = 16;
  localparam logic [16:0] PKT   = 17'h10000;  // event code for a pktend pulse

  logic        ifclk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic        flaga;
  logic [15:0] fd;
  logic        slwr;
  logic        pktend;
  logic [15:0] frame_cnt;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  // Bus events: {1'b0, fd} for a strobe, PKT for a pktend pulse.
  logic [16:0] ev_q [$];
  int          ev_t [$];
  int          cyc = 0;
  int          viol = 0;
  logic [15:0] prev_fd = '0;
  logic        prev_slwr = 1'b1;

  usb_slave_fifo_writer #(
    .DEPTH     (DEPTH),
    .SYNC_WORD (16'h55AA),
    .HEADER_EN (1'b1),
    .PKTEND_EN (1'b1)
  ) dut (
    .ifclk      (ifclk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_ready   (in_ready),
    .flaga      (flaga),
    .fd         (fd),
    .slwr       (slwr),
    .pktend     (pktend),
    .frame_cnt  (frame_cnt),
    .fifo_level (fifo_level)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  // Bus monitor: logs strobes/pktend and counts protocol violations
  // (fd not held from setup into strobe, back-to-back strobes, pktend with slwr).
  always @(negedge ifclk) begin
    cyc++;
    if (slwr === 1'b0) begin
      ev_q.push_back({1'b0, fd});
      ev_t.push_back(cyc);
      if (fd !== prev_fd) viol++;
      if (prev_slwr === 1'b0) viol++;
    end
    if (pktend === 1'b0) begin
      ev_q.push_back(PKT);
      ev_t.push_back(cyc);
      if (slwr !== 1'b1) viol++;
    end
    prev_fd   = fd;
    prev_slwr = slwr;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_events();
    ev_q.delete();
    ev_t.delete();
  endtask

  task automatic wait_events(input int n, input int budget);
    int k;
    k = 0;
    while (ev_q.size() < n && k < budget) begin
      @(negedge ifclk);
      k++;
    end
    repeat (6) @(negedge ifclk);
  endtask

  task automatic push_word(input logic sop, input logic eop, input logic [31:0] data);
    logic acc;
    int   k;
    in_valid = 1'b1;
    in_sop   = sop;
    in_eop   = eop;
    in_data  = data;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 100) begin
      acc = in_ready;
      @(negedge ifclk);
      k++;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout: in_ready stayed 0 for data %h", data);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
    flaga    = 1'b1;
    repeat (3) @(negedge ifclk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (slwr !== 1'b1) begin errors++; $display("FAIL rst_slwr: got %b want 1", slwr); end
    checks++; if (pktend !== 1'b1) begin errors++; $display("FAIL rst_pktend: got %b want 1", pktend); end
    checks++; if (fd !== 16'h0000) begin errors++; $display("FAIL rst_fd: got %h want 0000", fd); end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL rst_frame_cnt: got %h want 0000", frame_cnt); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    reset = 1'b0;
    @(negedge ifclk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    checks++; if (slwr !== 1'b1) begin errors++; $display("FAIL rel_slwr: got %b want 1", slwr); end
    checks++; if (fd !== 16'h0000) begin errors++; $display("FAIL rel_fd: got %h want 0000", fd); end
  endtask

  task automatic test_one_frame();
    logic [16:0] exp_ev [7] = '{17'h055AA, 17'h00000, 17'h05678, 17'h01234,
                                17'h0DEF0, 17'h09ABC, PKT};
    flaga = 1'b1;
    clear_events();
    push_word(1'b1, 1'b0, 32'h12345678);
    push_word(1'b0, 1'b1, 32'h9ABCDEF0);
    wait_events(7, 100);
    checks++;
    if (ev_q.size() != 7) begin
      errors++;
      $display("FAIL frame_count: got %0d events want 7", ev_q.size());
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= ev_q.size() || ev_q[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL frame_ev%0d: got %h want %h", i, (i < ev_q.size()) ? ev_q[i] : 17'h1FFFF, exp_ev[i]);
      end
    end
    // With flaga high every halfword costs 2 cycles and pktend 1 more.
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i + 1 >= ev_t.size() || ev_t[i+1] - ev_t[i] != ((i == 5) ? 1 : 2)) begin
        errors++;
        $display("FAIL frame_gap%0d: got %0d want %0d", i,
                 (i + 1 < ev_t.size()) ? ev_t[i+1] - ev_t[i] : -1, (i == 5) ? 1 : 2);
      end
    end
    checks++; if (frame_cnt !== 16'h0001) begin errors++; $display("FAIL frame_cnt1: got %h want 0001", frame_cnt); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL frame_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_backpressure();
    int bad;
    clear_events();
    flaga = 1'b0;
    push_word(1'b0, 1'b0, 32'hAAAA5555);
    // Accept edge, pop edge, setup edge: fd now shows the low half.
    repeat (3) @(negedge ifclk);
    bad = 0;
    repeat (10) begin
      if (slwr !== 1'b1 || fd !== 16'h5555) bad++;
      @(negedge ifclk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles want 0", bad); end
    checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL bp_no_strobe: got %0d events want 0", ev_q.size()); end
    flaga = 1'b1;
    wait_events(2, 50);
    checks++;
    if (ev_q.size() != 2) begin
      errors++;
      $display("FAIL bp_count: got %0d events want 2", ev_q.size());
    end else begin
      checks++; if (ev_q[0] !== 17'h05555) begin errors++; $display("FAIL bp_lo: got %h want 05555", ev_q[0]); end
      checks++; if (ev_q[1] !== 17'h0AAAA) begin errors++; $display("FAIL bp_hi: got %h want 0AAAA", ev_q[1]); end
    end
  endtask

  task automatic test_fifo_full();
    int acc_n;
    clear_events();
    flaga = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 40 && acc_n < 20; c++) begin
      logic a;
      in_valid = 1'b1;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_data  = {16'hB000 + 16'(acc_n), 16'hA000 + 16'(acc_n)};
      a = in_ready;
      @(negedge ifclk);
      if (a) acc_n++;
    end
    in_valid = 1'b0;
    // 16 words fill the FIFO; the first one accepted already sits in the
    // holding register, so 17 are accepted in total.
    checks++; if (acc_n != 17) begin errors++; $display("FAIL full_accepted: got %0d want 17", acc_n); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d want 16", fifo_level); end
    flaga = 1'b1;
    wait_events(34, 400);
    checks++;
    if (ev_q.size() != 34) begin
      errors++;
      $display("FAIL drain_count: got %0d events want 34", ev_q.size());
    end
    for (int i = 0; i < 34; i++) begin
      logic [16:0] e;
      e = (i % 2 == 0) ? {1'b0, 16'hA000 + 16'(i / 2)} : {1'b0, 16'hB000 + 16'(i / 2)};
      checks++;
      if (i >= ev_q.size() || ev_q[i] !== e) begin
        errors++;
        $display("FAIL drain_ev%0d: got %h want %h", i, (i < ev_q.size()) ? ev_q[i] : 17'h1FFFF, e);
      end
    end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_frame_wrap();
    logic [16:0] exp_ev [10] = '{17'h055AA, 17'h0FFFF, 17'h01111, 17'h03333, PKT,
                                 17'h055AA, 17'h00000, 17'h02222, 17'h04444, PKT};
    clear_events();
    flaga = 1'b1;
    // Preload the counter just below the wrap instead of running 65535 frames.
    force dut.frame_cnt = 16'hFFFF;
    @(negedge ifclk);
    release dut.frame_cnt;
    @(negedge ifclk);
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt); end
    push_word(1'b1, 1'b1, 32'h33331111);
    push_word(1'b1, 1'b1, 32'h44442222);
    wait_events(10, 100);
    checks++;
    if (ev_q.size() != 10) begin
      errors++;
      $display("FAIL wrap_count: got %0d events want 10", ev_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= ev_q.size() || ev_q[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL wrap_ev%0d: got %h want %h", i, (i < ev_q.size()) ? ev_q[i] : 17'h1FFFF, exp_ev[i]);
      end
    end
    checks++; if (frame_cnt !== 16'h0001) begin errors++; $display("FAIL wrap_cnt: got %h want 0001", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [16:0] exp_ev [5] = '{17'h055AA, 17'h00000, 17'h02468, 17'h01357, PKT};
    clear_events();
    flaga = 1'b1;
    push_word(1'b1, 1'b0, 32'hCAFEBEEF);
    // Stop the bus right after the low-half strobe so the FSM stalls in HI.
    k = 0;
    while (ev_q.size() < 3 && k < 50) begin
      @(negedge ifclk);
      #1;
      k++;
    end
    flaga = 1'b0;
    push_word(1'b0, 1'b0, 32'h0BAD0BAD);
    repeat (4) @(negedge ifclk);
    checks++; if (slwr !== 1'b1) begin errors++; $display("FAIL mid_stall_slwr: got %b want 1", slwr); end
    checks++; if (fd !== 16'hCAFE) begin errors++; $display("FAIL mid_stall_fd: got %h want cafe", fd); end
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL mid_stall_level: got %0d want 1", fifo_level); end
    checks++; if (ev_q.size() != 3) begin errors++; $display("FAIL mid_stall_events: got %0d want 3", ev_q.size()); end
    // flaga rises together with reset: reset must win, no strobe.
    reset = 1'b1;
    flaga = 1'b1;
    repeat (2) @(negedge ifclk);
    reset = 1'b0;
    @(negedge ifclk);
    checks++; if (ev_q.size() != 3) begin errors++; $display("FAIL mid_rst_events: got %0d want 3", ev_q.size()); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL mid_rst_level: got %0d want 0", fifo_level); end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL mid_rst_cnt: got %h want 0000", frame_cnt); end
    checks++; if (slwr !== 1'b1) begin errors++; $display("FAIL mid_rst_slwr: got %b want 1", slwr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    push_word(1'b1, 1'b1, 32'h13572468);
    wait_events(8, 100);
    checks++;
    if (ev_q.size() != 8) begin
      errors++;
      $display("FAIL mid_new_count: got %0d events want 8", ev_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i + 3 >= ev_q.size() || ev_q[i+3] !== exp_ev[i]) begin
        errors++;
        $display("FAIL mid_new_ev%0d: got %h want %h", i, (i + 3 < ev_q.size()) ? ev_q[i+3] : 17'h1FFFF, exp_ev[i]);
      end
    end
    checks++; if (frame_cnt !== 16'h0001) begin errors++; $display("FAIL mid_new_cnt: got %h want 0001", frame_cnt); end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL protocol: %0d bus timing violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_one_frame();
    test_backpressure();
    test_fifo_full();
    test_frame_wrap();
    test_reset_mid();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
